// File: rtl/mul_seq_pkg.sv
// Shared types and shift table for the sequential 24x24 multiplier controller.
// Partial products are issued in the order lo*lo, lo*hi, hi*lo, hi*hi.
package mul_seq_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef logic [1:0] idx_t;

   localparam int unsigned N_DEF = 24;
   localparam int unsigned SHIFT_DEF [4] = '{0, N_DEF/2, N_DEF/2, N_DEF};

   // Shift for a partial product, for operand width n.
   function automatic int unsigned shift_amt(input idx_t idx, input int unsigned n);
      case (idx)
         2'd0:    return 0;
         2'd3:    return n;
         default: return n / 2;
      endcase
   endfunction

endpackage

// File: rtl/mul_half_pipe.sv
// H x H unsigned multiplier with LAT register stages; a valid bit and an
// issue-index tag travel alongside each product. flush drops every valid bit.
module mul_half_pipe
   import mul_seq_pkg::*;
#(
   parameter int unsigned H   = 12,
   parameter int unsigned LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   input  idx_t           in_idx,
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic           out_valid,
   output idx_t           out_idx,
   output logic [2*H-1:0] p,
   output logic           busy
);

   logic [2*H-1:0] data_q [LAT];
   idx_t           idx_q  [LAT];
   logic [LAT-1:0] valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            data_q[i] <= '0;
            idx_q[i]  <= '0;
         end
         valid_q <= '0;
      end else begin
         data_q[0]  <= {{H{1'b0}}, a} * {{H{1'b0}}, b};
         idx_q[0]   <= in_idx;
         valid_q[0] <= in_valid & ~flush;
         for (int i = 1; i < LAT; i++) begin
            data_q[i]  <= data_q[i-1];
            idx_q[i]   <= idx_q[i-1];
            valid_q[i] <= valid_q[i-1] & ~flush;
         end
      end
   end

   assign p         = data_q[LAT-1];
   assign out_idx   = idx_q[LAT-1];
   assign out_valid = valid_q[LAT-1];
   assign busy      = |valid_q;

endmodule

// File: rtl/mul24_seq_ctrl.sv
// Full N x N unsigned multiply built from four time-multiplexed half-width
// products on a single pipelined H x H multiplier, with valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ISSUE | one partial product issued per cycle, idx 0..3
// DRAIN | waiting for the last tagged product to leave the multiplier
// DONE  | out_valid high, R held until out_ready
module mul24_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int unsigned N       = 24,
   parameter int unsigned MUL_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   M,
   input  logic [N-1:0]   Q,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] R,
   output logic           busy
);

   localparam int unsigned H = N / 2;

   state_t         state, state_nx;
   idx_t           idx;
   logic [N-1:0]   m_q, q_q;
   logic [2*N-1:0] acc, r_q;
   logic [H-1:0]   op_a, op_b;

   logic           pipe_valid, pipe_busy;
   idx_t           pipe_idx;
   logic [N-1:0]   pipe_p;
   logic [2*N-1:0] pp_shifted;

   // idx[1] selects the high half of M, idx[0] the high half of Q.
   assign op_a = idx[1] ? m_q[N-1:H] : m_q[H-1:0];
   assign op_b = idx[0] ? q_q[N-1:H] : q_q[H-1:0];

   mul_half_pipe #(.H(H), .LAT(MUL_LAT)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (state == ISSUE),
      .in_idx    (idx),
      .a         (op_a),
      .b         (op_b),
      .out_valid (pipe_valid),
      .out_idx   (pipe_idx),
      .p         (pipe_p),
      .busy      (pipe_busy)
   );

   assign pp_shifted = {{N{1'b0}}, pipe_p} << shift_amt(pipe_idx, N);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (in_valid)      state_nx = ISSUE;
         ISSUE: if (idx == 2'd3)   state_nx = DRAIN;
         DRAIN: if (!pipe_busy)    state_nx = DONE;
         DONE:  if (out_ready)     state_nx = IDLE;
         default:                  state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= '0;
         q_q <= '0;
         idx <= '0;
         acc <= '0;
         r_q <= '0;
      end else if (flush) begin
         idx <= '0;
         acc <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            m_q <= M;
            q_q <= Q;
            idx <= '0;
            acc <= '0;
         end
         if (state == ISSUE) idx <= idx + 2'd1;
         if (pipe_valid)     acc <= acc + pp_shifted;
         // acc is final once the pipe is empty; capture it as DONE is entered.
         if (state == DRAIN && !pipe_busy) r_q <= acc;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign R         = r_q;

endmodule
